// File: rtl/cpa_seq_pkg.sv
// Shared types and defaults for the sequential carry-lookahead adder.
// Holds the controller state encoding and operand geometry.
package cpa_seq_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SLICES = 4;
  localparam int N          = DEF_WIDTH * DEF_SLICES;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cpa_seq_ctrl_slice.sv
// Combinational WIDTH-bit carry-lookahead adder slice.
// Exposes the carry into the top bit for signed overflow detection.
module cpa_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products of g/p terms, no ripple chain.
  always_comb begin
    logic acc;
    logic pr;
    c    = '0;
    c[0] = cin;
    acc  = 1'b0;
    pr   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = g[i];
      pr  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pr & g[j]);
        pr  = pr & p[j];
      end
      acc    = acc | (pr & cin);
      c[i+1] = acc;
    end
  end

  assign s     = p ^ c[WIDTH-1:0];
  assign cout  = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/cpa_seq_ctrl.sv
// Wide add/subtract sequencer: one CLA slice reused per cycle,
// least significant slice first, carry held in a register.
module cpa_seq_ctrl
  import cpa_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SLICES = DEF_SLICES,
  localparam int NB    = WIDTH * SLICES,
  localparam int IW    = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  input  logic          cin,
  input  logic          sub,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [NB-1:0] sum,
  output logic          cout,
  output logic          ovf,
  output logic          busy
);

  state_t state;
  state_t state_nx;

  logic [IW-1:0]    idx;
  logic             carry;
  logic             c_msb;
  logic [NB-1:0]    a_r;
  logic [NB-1:0]    b_r;
  logic [NB-1:0]    sum_r;

  logic [WIDTH-1:0] sl_a;
  logic [WIDTH-1:0] sl_b;
  logic [WIDTH-1:0] sl_s;
  logic             sl_cout;
  logic             sl_cmsb;
  logic             last;
  logic             accept;

  assign last   = (idx == IW'(SLICES - 1));
  assign accept = start_valid && start_ready;
  assign sl_a   = a_r[idx*WIDTH +: WIDTH];
  assign sl_b   = b_r[idx*WIDTH +: WIDTH];

  cpa_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_cout),
    .c_msb(sl_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      c_msb <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
    end else if (accept) begin
      idx   <= '0;
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= sub | cin;
      c_msb <= 1'b0;
      sum_r <= '0;
    end else if (state == RUN) begin
      sum_r[idx*WIDTH +: WIDTH] <= sl_s;
      carry <= sl_cout;
      if (last) begin
        c_msb <= sl_cmsb;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Result outputs read zero outside DONE.
  assign sum  = res_valid ? sum_r : '0;
  assign cout = res_valid & carry;
  assign ovf  = res_valid & (c_msb ^ carry);

endmodule

// File: tb/tb_cpa_seq_ctrl.sv
// Directed scoreboard bench for the sequential CLA adder.
// Expected results come from a flat 33-bit reference model.
module tb_cpa_seq_ctrl;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  exp_t sb[$];
  int   vecs;
  int   errs;

  cpa_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sub        (sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] x, logic [31:0] y,
                                 logic c, logic s);
    logic [31:0] yy;
    logic        ci;
    logic [32:0] full;
    logic [31:0] low;
    exp_t        e;
    yy   = s ? ~y : y;
    ci   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
    low  = {1'b0, x[30:0]} + {1'b0, yy[30:0]} + {31'd0, ci};
    e.s  = full[31:0];
    e.co = full[32];
    e.ov = low[31] ^ full[32];
    return e;
  endfunction

  // Drive operands, accept on the next edge, then scramble the inputs.
  task automatic send(logic [31:0] ta, logic [31:0] tb_, logic tc, logic ts);
    @(negedge clk);
    a           = ta;
    b           = tb_;
    cin         = tc;
    sub         = ts;
    start_valid = 1'b1;
    sb.push_back(model(ta, tb_, tc, ts));
    chk("start_ready_before_accept", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a           = $urandom;
    b           = $urandom;
    cin         = ~tc;
    sub         = ~ts;
  endtask

  task automatic collect(int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 32'd4);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("sum", sum, e.s);
    chk("cout", {31'd0, cout}, {31'd0, e.co});
    chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
    chk("busy_done", {31'd0, busy}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      start_valid = 1'b1;
      a           = $urandom;
      b           = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_sum", sum, e.s);
      chk("hold_cout", {31'd0, cout}, {31'd0, e.co});
      chk("hold_ovf", {31'd0, ovf}, {31'd0, e.ov});
      chk("hold_start_ready", {31'd0, start_ready}, 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_res_valid", {31'd0, res_valid}, 32'd0);
    chk("post_start_ready", {31'd0, start_ready}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("stay_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    rst_n = 1'b1;

    send(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
    collect(0);
    send(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    collect(0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    collect(0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    collect(0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    collect(3);

    for (int i = 0; i < 4; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
      collect(i % 2);
    end

    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_sum", sum, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_start_ready", {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 1'b0);
    collect(0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
